// File: rtl/calc_key_capture.sv
// ---------------------------------------------------------------------------
// calc_key_capture
//
// Front-end stage for the calculator controller. Turns raw keypad activity
// (a level-sensitive key_valid plus a 5-bit key_code) into one event per
// press, accumulates decimal digits into a 32-bit unsigned operand and
// latches the most recent operator.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   key_valid  in   1   high while a key is held
//   key_code   in   5   0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14-31 invalid
//   num_clr    in   1   clears operand, digit count and overflow while high
//   number     out  32  accumulated operand
//   op_code    out  2   last operator (0 '+', 1 '-', 2 '*', 3 '=')
//   rec_num    out  1   one-cycle pulse per accepted digit
//   rec_op     out  1   one-cycle pulse per accepted operator
//   overflow   out  1   sticky, set when a digit is dropped at MAX_DIGITS
//
// Optional feature macro: KEY_DEBOUNCE_EN
//   When defined, a press must stay high for DEBOUNCE_CYCLES cycles (the
//   rising-edge cycle is the first) before it is decoded. When undefined the
//   event is decoded on the rising-edge cycle itself.
// ---------------------------------------------------------------------------
module calc_key_capture #(
   parameter int MAX_DIGITS = 9
`ifdef KEY_DEBOUNCE_EN
   ,
   parameter int DEBOUNCE_CYCLES = 4
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [4:0]  key_code,
   input  logic        num_clr,
   output logic [31:0] number,
   output logic [1:0]  op_code,
   output logic        rec_num,
   output logic        rec_op,
   output logic        overflow
);

   localparam int             CW      = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_DIGITS);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_ACCEPT   = 2'd2,
      S_HELD     = 2'd3
   } state_t;

   state_t         r_state;
   logic           r_prev;
   logic [CW-1:0]  r_cnt;
   logic [31:0]    r_number;
   logic [1:0]     r_op;
   logic           r_rec_num;
   logic           r_rec_op;
   logic           r_ovf;

`ifdef KEY_DEBOUNCE_EN
   localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   logic [DBW-1:0] r_db_cnt;
`endif

   logic           w_edge;
   logic           w_fire;
   logic           w_is_digit;
   logic           w_is_op;
   logic [31:0]    w_base_num;
   logic [CW-1:0]  w_base_cnt;
   logic           w_digit_ok;
   logic           w_digit_drop;
   logic [31:0]    w_next_num;

   assign w_edge = key_valid && !r_prev;

   // w_fire marks the cycle in which the held key_code is decoded.
`ifdef KEY_DEBOUNCE_EN
   assign w_fire = (r_state == S_DEBOUNCE) && key_valid && (r_db_cnt == DB_LAST);
`else
   assign w_fire = (r_state == S_IDLE) && w_edge;
`endif

   assign w_is_digit = (key_code <= 5'd9);
   assign w_is_op    = (key_code >= 5'd10) && (key_code <= 5'd13);

   // num_clr acts first, so a digit in the same cycle loads onto a zero operand.
   assign w_base_num   = num_clr ? 32'd0 : r_number;
   assign w_base_cnt   = num_clr ? {CW{1'b0}} : r_cnt;
   assign w_digit_ok   = w_fire && w_is_digit && (w_base_cnt < MAX_CNT);
   assign w_digit_drop = w_fire && w_is_digit && !(w_base_cnt < MAX_CNT);
   assign w_next_num   = (w_base_num << 3) + (w_base_num << 1) + {28'd0, key_code[3:0]};

   // Press FSM plus operand/operator registers and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_prev    <= 1'b0;
         r_cnt     <= {CW{1'b0}};
         r_number  <= 32'd0;
         r_op      <= 2'd0;
         r_rec_num <= 1'b0;
         r_rec_op  <= 1'b0;
         r_ovf     <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
         r_db_cnt  <= {DBW{1'b0}};
`endif
      end else begin
         r_prev    <= key_valid;
         r_rec_num <= w_digit_ok;
         r_rec_op  <= w_fire && w_is_op;
         r_number  <= w_digit_ok ? w_next_num : w_base_num;
         r_cnt     <= w_digit_ok ? (w_base_cnt + CW'(1)) : w_base_cnt;
         r_ovf     <= num_clr ? 1'b0 : (r_ovf | w_digit_drop);

         // code-10 for codes 10..13 equals (code[1:0] + 2) mod 4.
         if (w_fire && w_is_op) begin
            r_op <= key_code[1:0] + 2'd2;
         end else begin
            r_op <= r_op;
         end

         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
`ifdef KEY_DEBOUNCE_EN
                  r_state  <= S_DEBOUNCE;
                  r_db_cnt <= {DBW{1'b0}};
`else
                  r_state  <= S_ACCEPT;
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
`ifdef KEY_DEBOUNCE_EN
            S_DEBOUNCE: begin
               if (!key_valid) begin
                  r_state <= S_IDLE;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state <= S_ACCEPT;
               end else begin
                  r_db_cnt <= r_db_cnt + DBW'(1);
               end
            end
`endif
            S_ACCEPT: begin
               r_state <= S_HELD;
            end
            S_HELD: begin
               if (!key_valid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_HELD;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign number   = r_number;
   assign op_code  = r_op;
   assign rec_num  = r_rec_num;
   assign rec_op   = r_rec_op;
   assign overflow = r_ovf;

endmodule

// File: doc/calc_key_capture.md
Name: calc_key_capture

Overview:
- Front-end stage for the calculator control FSM.
- Converts raw keypad events (key code plus a level-sensitive "pressed" flag) into single-cycle rec_num / rec_op strobes.
- Accumulates decimal digits into a 32-bit unsigned operand and latches the last operator code.
- Presents number/op_code for the processor-save stage; the controller clears the operand via num_clr.

Parameters:
- MAX_DIGITS, 9, max accepted digits per operand; 9 keeps the value < 2^32.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a press is accepted; only used with KEY_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  high while a key is held.
- key_code  input  5  0-9 digit; 10 '+'; 11 '-'; 12 '*'; 13 '='; 14-31 invalid.
- num_clr  input  1  clears operand and digit count while high.
- number  output  32  accumulated operand, unsigned binary.
- op_code  output  2  last operator: 0 '+', 1 '-', 2 '*', 3 '='.
- rec_num  output  1  one-cycle pulse per accepted digit.
- rec_op  output  1  one-cycle pulse per accepted operator.
- overflow  output  1  sticky; set when a digit is dropped due to MAX_DIGITS.

Behaviour:
- Reset (rst high at an edge):
  - number=0, op_code=0, rec_num=0, rec_op=0, overflow=0, digit count=0.
  - Press FSM goes to IDLE. Reset overrides all other inputs.
- Press FSM states:
  - IDLE: key_valid rising edge (prev=0, now=1) -> ACCEPT.
  - ACCEPT: one cycle; decode the key_code sampled at the edge cycle -> HELD.
  - HELD: waits for key_valid=0 -> IDLE.
  - One press yields exactly one event, however long it is held.
  - Re-press requires at least one cycle of key_valid=0.
- Latency: edge sampled at cycle n; strobe and register update visible at cycle n+1.
- Strobes are registered and never high on consecutive cycles for a single press.
- Digit d accepted (count < MAX_DIGITS):
  - number <= number*10 + d, with number*10 = (number<<3)+(number<<1).
  - count++; rec_num=1.
- Digit with count == MAX_DIGITS:
  - Ignored; number unchanged; no rec_num; overflow <= 1.
- Operator (10-13): op_code <= code-10; rec_op=1; number and count unchanged.
- Invalid code (14-31): no strobe, no register change; FSM still goes to HELD.
- num_clr high:
  - number <= 0; count <= 0; overflow <= 0; op_code unchanged.
  - If a digit is accepted in the same cycle, number <= d and count <= 1 (clear first, then load).
  - If an operator is accepted in the same cycle, both the clear and the op latch take effect.
- Leading zeros are accepted and count toward MAX_DIGITS.
- Reset mid-press (key still held): FSM returns to IDLE. Since prev is reset to 0, a key held through reset re-triggers one event after rst deasserts (documented, intended).

Optional Feature:
- Macro: KEY_DEBOUNCE_EN.
- Defined: adds a DEBOUNCE state between IDLE and ACCEPT.
  - Counter runs while key_valid=1; reaching DEBOUNCE_CYCLES -> ACCEPT.
  - Any key_valid=0 returns to IDLE with no event.
  - key_code is sampled on the final debounce cycle.
  - Latency = DEBOUNCE_CYCLES+1 cycles from the rising edge.
- Undefined: no debounce counter or state; latency 1 cycle as above.

Test Plan:
- Reset, then press '4', '2', '7' (each held 3 cycles, 2 cycles apart) -> 3 rec_num pulses; number=427; count=3; no rec_op.
- number=427, press '*' held 10 cycles -> exactly one rec_op pulse; op_code=2; number stays 427.
- Press ten '9' digits (MAX_DIGITS=9) -> 9 rec_num pulses; number=999999999; 10th press: no pulse, overflow=1.
- num_clr high in the same cycle a '5' is accepted -> number=5, count=1, overflow=0.
- key_code=20 pressed -> no strobe, registers unchanged; then key_valid held across rst pulse -> one digit event after rst deasserts.
- KEY_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle glitch on '3' -> nothing; stable 6-cycle '3' -> rec_num 5 cycles after the edge, number=3.
